// File: rtl/serial_add_pkg.sv
// Shared types for the serial-adder issue controller: FSM states, operand pair, counter sizing.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    CAPT  = 2'd3
  } sa_state_e;

  // Operand width carried through the FIFO; the top's NO_BIT must equal this.
  localparam int SA_NO_BIT = 4;

  typedef struct packed {
    logic [SA_NO_BIT-1:0] a;
    logic [SA_NO_BIT-1:0] b;
  } op_pair_t;

  function automatic int cnt_w(input int add_lat);
    return $clog2(add_lat) + 1;
  endfunction

endpackage

// File: rtl/serial_add_op_fifo.sv
// Synchronous operand-pair FIFO; pointers carry an extra wrap bit to tell full from empty.
module serial_add_op_fifo
  import serial_add_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_push,
  input  op_pair_t i_data,
  input  logic     i_pop,
  output op_pair_t o_data,
  output logic     o_full,
  output logic     o_empty
);

  localparam int AW = $clog2(DEPTH);

  op_pair_t       mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic           push_ok, pop_ok;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;
  assign o_data  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is data only; flushing the pointers is enough to empty it.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/serial_add_issue_ctrl.sv
// Issue/capture controller for the fixed-latency serial adder.
// Optional build macro SERIAL_ADD_CHECK_EN adds o_err, a sticky sum-mismatch flag.
module serial_add_issue_ctrl
  import serial_add_pkg::*;
#(
  parameter int NO_BIT  = SA_NO_BIT,
  parameter int DEPTH   = 4,
  parameter int ADD_LAT = NO_BIT + 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_op_valid,
  output logic              o_op_ready,
  input  logic [NO_BIT-1:0] i_op_a,
  input  logic [NO_BIT-1:0] i_op_b,
  output logic              o_add_rstn,
  output logic              o_start,
  output logic [NO_BIT-1:0] o_dinA,
  output logic [NO_BIT-1:0] o_dinB,
  input  logic [NO_BIT:0]   i_sum,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [NO_BIT:0]   o_res,
  output logic              o_busy
`ifdef SERIAL_ADD_CHECK_EN
  ,
  output logic              o_err
`endif
);

  localparam int CNT_W = cnt_w(ADD_LAT);

  sa_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              add_rstn_q;
  logic [NO_BIT-1:0] din_a_q, din_a_d;
  logic [NO_BIT-1:0] din_b_q, din_b_d;
  logic [NO_BIT:0]   res_q, res_d;
  logic              res_valid_q, res_valid_d;
  logic              fifo_full, fifo_empty, push, pop;
  op_pair_t          head, wdata;

  assign push       = i_op_valid && !fifo_full;
  assign wdata.a    = i_op_a;
  assign wdata.b    = i_op_b;

  serial_add_op_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  (wdata),
    .i_pop   (pop),
    .o_data  (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_op_ready  = !fifo_full;
  assign o_add_rstn  = add_rstn_q;
  assign o_start     = (state_q == ISSUE);
  assign o_dinA      = din_a_q;
  assign o_dinB      = din_b_q;
  assign o_res       = res_q;
  assign o_res_valid = res_valid_q;
  assign o_busy      = (state_q != IDLE) || !fifo_empty;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    din_a_d     = din_a_q;
    din_b_d     = din_b_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    pop         = 1'b0;
    if (res_valid_q && i_res_ready) res_valid_d = 1'b0;
    unique case (state_q)
      // Gating on !res_valid keeps an unconsumed result from being overwritten.
      IDLE: begin
        if (!fifo_empty && add_rstn_q && !res_valid_q) begin
          pop     = 1'b1;
          din_a_d = head.a;
          din_b_d = head.b;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(ADD_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) state_d = CAPT;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      CAPT: begin
        res_d       = i_sum;
        res_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      add_rstn_q  <= 1'b0;
      din_a_q     <= '0;
      din_b_q     <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      add_rstn_q  <= 1'b1;
      din_a_q     <= din_a_d;
      din_b_q     <= din_b_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
    end
  end

`ifdef SERIAL_ADD_CHECK_EN
  logic            err_q, err_d;
  logic [NO_BIT:0] ref_sum;

  always_comb begin
    ref_sum = {1'b0, din_a_q} + {1'b0, din_b_q};
    err_d   = err_q;
    if (state_q == CAPT && i_sum != ref_sum) err_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign o_err = err_q;
`endif

endmodule

// File: tb/tb_serial_add_issue_ctrl.sv
// Directed bench for serial_add_issue_ctrl with a behavioural fixed-latency adder model.
module tb_serial_add_issue_ctrl;

  localparam int NO_BIT  = 4;
  localparam int DEPTH   = 4;
  localparam int ADD_LAT = 7;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_op_valid = 1'b0;
  logic              i_res_ready = 1'b1;
  logic [NO_BIT-1:0] i_op_a = '0;
  logic [NO_BIT-1:0] i_op_b = '0;
  logic [NO_BIT:0]   i_sum;
  logic              o_op_ready, o_add_rstn, o_start, o_res_valid, o_busy;
  logic [NO_BIT-1:0] o_dinA, o_dinB;
  logic [NO_BIT:0]   o_res;
`ifdef SERIAL_ADD_CHECK_EN
  logic              o_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit corrupt = 1'b0;

  serial_add_issue_ctrl #(
    .NO_BIT  (NO_BIT),
    .DEPTH   (DEPTH),
    .ADD_LAT (ADD_LAT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_op_valid  (i_op_valid),
    .o_op_ready  (o_op_ready),
    .i_op_a      (i_op_a),
    .i_op_b      (i_op_b),
    .o_add_rstn  (o_add_rstn),
    .o_start     (o_start),
    .o_dinA      (o_dinA),
    .o_dinB      (o_dinB),
    .i_sum       (i_sum),
    .o_res_valid (o_res_valid),
    .i_res_ready (i_res_ready),
    .o_res       (o_res),
    .o_busy      (o_busy)
`ifdef SERIAL_ADD_CHECK_EN
    ,
    .o_err       (o_err)
`endif
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Adder model: the true sum is presented only during cycle T+ADD_LAT, garbage otherwise.
  logic [NO_BIT-1:0] m_a, m_b;
  int                m_k;
  bit                m_busy;
  always @(posedge i_clk) begin
    if (i_rst) begin
      m_busy <= 1'b0;
      m_k    <= 0;
      i_sum  <= '0;
    end else if (o_start) begin
      m_a    <= o_dinA;
      m_b    <= o_dinB;
      m_k    <= 1;
      m_busy <= 1'b1;
      i_sum  <= ~({1'b0, o_dinA} + {1'b0, o_dinB});
    end else if (m_busy) begin
      m_k <= m_k + 1;
      if (m_k + 1 == ADD_LAT) begin
        i_sum <= corrupt ? '0 : ({1'b0, m_a} + {1'b0, m_b});
      end else begin
        i_sum <= ~({1'b0, m_a} + {1'b0, m_b});
        if (m_k + 1 > ADD_LAT) m_busy <= 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_one(input logic [NO_BIT-1:0] a, input logic [NO_BIT-1:0] b, output bit ok);
    int n = 0;
    while (!o_op_ready && n < 40) begin
      tick();
      n++;
    end
    ok         = o_op_ready;
    i_op_a     = a;
    i_op_b     = b;
    i_op_valid = ok;
    tick();
    i_op_valid = 1'b0;
  endtask

  task automatic wait_start(input int budget, output bit ok);
    int n = 0;
    while (!o_start && n < budget) begin
      tick();
      n++;
    end
    ok = o_start;
  endtask

  task automatic wait_res(input int budget, output bit ok);
    int n = 0;
    while (!o_res_valid && n < budget) begin
      tick();
      n++;
    end
    ok = o_res_valid;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_op_valid = 1'b0;
    i_res_ready = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (o_add_rstn !== 1'b0 || o_start !== 1'b0 || o_res_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_ctrl: got rstn=%b start=%b vld=%b busy=%b, want 0 0 0 0",
               o_add_rstn, o_start, o_res_valid, o_busy);
    end
    n_cmp++;
    if (o_dinA !== '0 || o_dinB !== '0 || o_res !== '0) begin
      n_bad++;
      $display("FAIL rst_data: got dinA=%0d dinB=%0d res=%0d, want 0 0 0", o_dinA, o_dinB, o_res);
    end
    n_cmp++;
    if (o_op_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_ready: got %b, want 1", o_op_ready);
    end
`ifdef SERIAL_ADD_CHECK_EN
    n_cmp++;
    if (o_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_err: got %b, want 0", o_err);
    end
`endif
    i_rst = 1'b0;
    tick();
    n_cmp++;
    if (o_add_rstn !== 1'b1) begin
      n_bad++;
      $display("FAIL rstn_release: got %b, want 1", o_add_rstn);
    end
  endtask

  task automatic test_single();
    bit ok, stable;
    i_res_ready = 1'b1;
    push_one(4'd9, 4'd8, ok);
    wait_start(20, ok);
    n_cmp++;
    if (!ok || o_dinA !== 4'd9 || o_dinB !== 4'd8 || o_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_issue: got start=%b dinA=%0d dinB=%0d busy=%b, want 1 9 8 1",
               ok, o_dinA, o_dinB, o_busy);
    end
    stable = 1'b1;
    for (int j = 1; j <= ADD_LAT; j++) begin
      tick();
      if (o_start !== 1'b0 || o_dinA !== 4'd9 || o_dinB !== 4'd8 || o_res_valid !== 1'b0) stable = 1'b0;
    end
    n_cmp++;
    if (!stable) begin
      n_bad++;
      $display("FAIL single_hold: got operands/start unstable in T+1..T+7, want 9/8 held, start 0");
    end
    tick();
    n_cmp++;
    if (o_res_valid !== 1'b1 || o_res !== 5'd17 || o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_result: got vld=%b res=%0d busy=%b at T+8, want 1 17 0",
               o_res_valid, o_res, o_busy);
    end
    tick();
    n_cmp++;
    if (o_res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_consume: got vld=%b, want 0", o_res_valid);
    end
  endtask

  task automatic test_back_to_back();
    int pa[5] = '{15, 0, 15, 6, 9};
    int pb[5] = '{15, 0, 1, 7, 2};
    int er[5] = '{30, 0, 16, 13, 11};
    i_res_ready = 1'b1;
    fork
      begin
        bit ok, all_ok;
        all_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
          push_one(4'(pa[i]), 4'(pb[i]), ok);
          all_ok &= ok;
        end
        n_cmp++;
        if (!all_ok || o_op_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_full: got pushes_ok=%b ready=%b after 5th push, want 1 0", all_ok, o_op_ready);
        end
      end
      begin
        bit ok;
        int prev;
        prev = 0;
        for (int r = 0; r < 5; r++) begin
          wait_res(40, ok);
          n_cmp++;
          if (!ok || o_res !== 5'(er[r])) begin
            n_bad++;
            $display("FAIL b2b_res%0d: got vld=%b res=%0d, want 1 %0d", r, ok, o_res, er[r]);
          end
          if (r > 0) begin
            n_cmp++;
            if (cyc - prev < ADD_LAT + 2) begin
              n_bad++;
              $display("FAIL b2b_gap%0d: got %0d cycles, want >= %0d", r, cyc - prev, ADD_LAT + 2);
            end
          end
          prev = cyc;
          tick();
        end
      end
    join
  endtask

  task automatic test_res_backpressure();
    bit ok, stable;
    i_res_ready = 1'b0;
    push_one(4'd1, 4'd2, ok);
    push_one(4'd7, 4'd7, ok);
    push_one(4'd8, 4'd8, ok);
    wait_res(40, ok);
    n_cmp++;
    if (!ok || o_res !== 5'd3) begin
      n_bad++;
      $display("FAIL bp_first: got vld=%b res=%0d, want 1 3", ok, o_res);
    end
    stable = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (o_start !== 1'b0 || o_res_valid !== 1'b1 || o_res !== 5'd3 || o_busy !== 1'b1) stable = 1'b0;
    end
    n_cmp++;
    if (!stable) begin
      n_bad++;
      $display("FAIL bp_hold: got issue or result change while held, want no start, res 3 held");
    end
    i_res_ready = 1'b1;
    tick();
    n_cmp++;
    if (o_res_valid !== 1'b0 || o_start !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release1: got vld=%b start=%b, want 0 0", o_res_valid, o_start);
    end
    tick();
    n_cmp++;
    if (o_start !== 1'b1 || o_dinA !== 4'd7) begin
      n_bad++;
      $display("FAIL bp_release2: got start=%b dinA=%0d, want 1 7", o_start, o_dinA);
    end
    wait_res(40, ok);
    n_cmp++;
    if (!ok || o_res !== 5'd14) begin
      n_bad++;
      $display("FAIL bp_second: got vld=%b res=%0d, want 1 14", ok, o_res);
    end
    tick();
    wait_res(40, ok);
    n_cmp++;
    if (!ok || o_res !== 5'd16) begin
      n_bad++;
      $display("FAIL bp_third: got vld=%b res=%0d, want 1 16", ok, o_res);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    i_res_ready = 1'b1;
    push_one(4'd5, 4'd5, ok);
    push_one(4'd2, 4'd2, ok);
    wait_start(20, ok);
    repeat (3) tick();
    i_rst = 1'b1;
    tick();
    n_cmp++;
    if (!ok || o_add_rstn !== 1'b0 || o_start !== 1'b0 || o_res_valid !== 1'b0 ||
        o_busy !== 1'b0 || o_op_ready !== 1'b1 || o_dinA !== '0) begin
      n_bad++;
      $display("FAIL midrst_state: got rstn=%b start=%b vld=%b busy=%b ready=%b dinA=%0d, want 0 0 0 0 1 0",
               o_add_rstn, o_start, o_res_valid, o_busy, o_op_ready, o_dinA);
    end
    i_rst = 1'b0;
    tick();
    push_one(4'd3, 4'd4, ok);
    wait_res(40, ok);
    n_cmp++;
    if (!ok || o_res !== 5'd7) begin
      n_bad++;
      $display("FAIL midrst_after: got vld=%b res=%0d, want 1 7", ok, o_res);
    end
    tick();
  endtask

  task automatic test_push_pop_same();
    bit ok;
    int er[5] = '{21, 25, 16, 2, 16};
    i_res_ready = 1'b0;
    push_one(4'd4, 4'd4, ok);
    push_one(4'd10, 4'd11, ok);
    push_one(4'd12, 4'd13, ok);
    wait_res(40, ok);
    n_cmp++;
    if (!ok || o_res !== 5'd8) begin
      n_bad++;
      $display("FAIL pp_first: got vld=%b res=%0d, want 1 8", ok, o_res);
    end
    i_res_ready = 1'b1;
    tick();
    i_op_a = 4'd14;
    i_op_b = 4'd2;
    i_op_valid = 1'b1;
    tick();
    n_cmp++;
    if (o_start !== 1'b1 || o_dinA !== 4'd10) begin
      n_bad++;
      $display("FAIL pp_same_edge: got start=%b dinA=%0d, want 1 10", o_start, o_dinA);
    end
    i_op_a = 4'd1;
    i_op_b = 4'd1;
    tick();
    n_cmp++;
    if (o_op_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL pp_count3: got ready=%b, want 1", o_op_ready);
    end
    i_op_a = 4'd11;
    i_op_b = 4'd5;
    tick();
    i_op_valid = 1'b0;
    n_cmp++;
    if (o_op_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL pp_count4: got ready=%b, want 0", o_op_ready);
    end
    for (int r = 0; r < 5; r++) begin
      wait_res(40, ok);
      n_cmp++;
      if (!ok || o_res !== 5'(er[r])) begin
        n_bad++;
        $display("FAIL pp_order%0d: got vld=%b res=%0d, want 1 %0d", r, ok, o_res, er[r]);
      end
      tick();
    end
  endtask

`ifdef SERIAL_ADD_CHECK_EN
  task automatic test_check();
    bit ok;
    i_res_ready = 1'b1;
    corrupt = 1'b1;
    push_one(4'd2, 4'd3, ok);
    wait_res(40, ok);
    n_cmp++;
    if (!ok || o_res !== 5'd0 || o_err !== 1'b1) begin
      n_bad++;
      $display("FAIL chk_set: got vld=%b res=%0d err=%b, want 1 0 1", ok, o_res, o_err);
    end
    tick();
    corrupt = 1'b0;
    push_one(4'd1, 4'd1, ok);
    wait_res(40, ok);
    n_cmp++;
    if (!ok || o_res !== 5'd2 || o_err !== 1'b1) begin
      n_bad++;
      $display("FAIL chk_sticky: got vld=%b res=%0d err=%b, want 1 2 1", ok, o_res, o_err);
    end
    tick();
    i_rst = 1'b1;
    tick();
    n_cmp++;
    if (o_err !== 1'b0) begin
      n_bad++;
      $display("FAIL chk_clear: got err=%b, want 0", o_err);
    end
    i_rst = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_res_backpressure();
    test_reset_mid();
    test_push_pop_same();
`ifdef SERIAL_ADD_CHECK_EN
    test_check();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
